spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  Transfer sequencer for the SPI master.
//  - Starts a character transfer on go and drives tip/last_clk into spi_clgen.
//  - Consumes spi_clgen edge pulses (cpol_0 = SCLK rising pulse, cpol_1 = SCLK falling pulse).
//  - Issues load/shift/sample strobes to the shift register, drives slave selects, raises completion interrupt.
// PARAMETERS
//  CHAR_LEN_BITS  7  width of char_len; char_len==0 means 2**CHAR_LEN_BITS bits (128)
//  SS_NB          8  number of slave-select lines
// PORTS
//  wb_clk_in   in   1              system clock; all logic on rising edge
//  wb_rst      in   1              synchronous reset, active high
//  go          in   1              start request; level, sampled only in IDLE
//  char_len    in   CHAR_LEN_BITS  bits per transfer (0 => 128)
//  tx_negedge  in   1              1: shift TX on SCLK falling pulse (cpol_1); 0: rising (cpol_0)
//  rx_negedge  in   1              1: sample RX on cpol_1; 0: on cpol_0
//  ie          in   1              interrupt enable
//  int_ack     in   1              clears int_o
//  auto_ss     in   1              1: SS asserted only during transfer; 0: SS follows ss_sel
//  ss_sel      in   SS_NB          selected slaves (1 = selected)
//  cpol_0      in   1              from spi_clgen: 1-cycle pulse at SCLK rising edge
//  cpol_1      in   1              from spi_clgen: 1-cycle pulse at SCLK falling edge
//  tip         out  1              transfer in progress, to spi_clgen
//  last_clk    out  1              final SCLK cycle indicator, to spi_clgen
//  tx_load     out  1              1-cycle pulse: load TX data, present bit 0
//  tx_shift    out  1              1-cycle pulse: advance TX to next bit
//  rx_sample   out  1              1-cycle pulse: capture MISO bit
//  done        out  1              1-cycle pulse at end of transfer
//  int_o       out  1              sticky interrupt
//  ss_pad_o    out  SS_NB          slave selects, active low
//  busy        out  1              state != IDLE
// BEHAVIOUR
//  - Reset (wb_rst=1 at clock edge): state IDLE, counters 0, int_o=0, all pulses 0, tip=0, last_clk=0, ss_pad_o all 1.
//    Applies mid-transfer too; in-flight edge pulses are dropped.
//  - len = (char_len==0) ? 128 : char_len; counters are CHAR_LEN_BITS+1 bits wide.
//  - tx_edge = tx_negedge ? cpol_1 : cpol_0; rx_edge = rx_negedge ? cpol_1 : cpol_0.
//  - IDLE: go=1 -> LOAD next cycle. tx_rem<=len-1, rx_rem<=len.
//  - LOAD (1 cycle): tx_load=1, tip=1 -> RUN.
//  - RUN: tip=1.
//    - tx_edge && tx_rem!=0 -> tx_shift=1 (same cycle, combinational from registered state), tx_rem--.
//    - tx_edge && tx_rem==0 -> no shift.
//    - rx_edge -> rx_sample=1, rx_rem--.
//    - rx_edge && rx_rem==1 -> DONE next cycle.
//    - tx_edge and rx_edge in the same cycle (tx_negedge==rx_negedge): both actions occur.
//  - last_clk = (state==RUN) && (rx_rem==1).
//  - DONE (1 cycle): done=1, tip=0; int_o set if ie -> IDLE.
//    A go held high starts the next transfer from IDLE one cycle later (min 1 idle cycle between transfers).
//  - go while not IDLE: ignored, never queued.
//  - int_o: set in DONE when ie=1; cleared by int_ack. Set wins if both occur in the same cycle.
//  - ss_pad_o (registered):
//    - auto_ss=0: ~ss_sel.
//    - auto_ss=1: ~ss_sel in LOAD/RUN/DONE, all 1 in IDLE.
//  - Latency: go sampled -> tx_load = 1 cycle; last rx_edge -> done = 1 cycle.
//  - Exactly len rx_sample, len-1 tx_shift, 1 tx_load per transfer.
//  - char_len, tx_negedge and rx_negedge are sampled only at go; changes mid-transfer have no effect.
// TESTING
//  1. Reset mid-RUN (after 3 samples) -> next cycle tip=0, ss_pad_o=8'hFF, busy=0, no further pulses.
//  2. char_len=8, rx_negedge=0, tx_negedge=1, alternating cpol_0/cpol_1 every 2 cycles
//     -> 1 tx_load, 7 tx_shift, 8 rx_sample; last_clk high only after 7th sample; done 1 cycle after 8th.
//  3. char_len=0 -> exactly 128 rx_sample and 127 tx_shift before done.
//  4. tx_negedge=rx_negedge=1 (cpol_1 only) -> tx_shift and rx_sample coincide; counts as in (2).
//  5. auto_ss=1, ss_sel=8'h05 -> ss_pad_o=8'hFA from cycle after go through DONE, 8'hFF otherwise.
//     auto_ss=0 -> 8'hFA constant.
//  6. ie=1, int_ack pulsed in DONE cycle -> int_o=1 (set wins); go pulsed during RUN -> ignored, no second transfer.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: runs one character transfer per go, turning
// spi_clgen edge pulses into load/shift/sample strobes for the shift
// register, and managing slave selects and the completion interrupt.
module spi_xfer_ctrl #(
  parameter int unsigned CHAR_LEN_BITS = 7,
  parameter int unsigned SS_NB         = 8
) (
  input  logic                     wb_clk_in,
  input  logic                     wb_rst,
  input  logic                     go,
  input  logic [CHAR_LEN_BITS-1:0] char_len,
  input  logic                     tx_negedge,
  input  logic                     rx_negedge,
  input  logic                     ie,
  input  logic                     int_ack,
  input  logic                     auto_ss,
  input  logic [SS_NB-1:0]         ss_sel,
  input  logic                     cpol_0,
  input  logic                     cpol_1,
  output logic                     tip,
  output logic                     last_clk,
  output logic                     tx_load,
  output logic                     tx_shift,
  output logic                     rx_sample,
  output logic                     done,
  output logic                     int_o,
  output logic [SS_NB-1:0]         ss_pad_o,
  output logic                     busy
);

  // One extra bit so a full 2**CHAR_LEN_BITS length fits in the counters.
  localparam int unsigned CW = CHAR_LEN_BITS + 1;
  localparam logic [CW-1:0] REM_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LEN_FULL = {1'b1, {CHAR_LEN_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     tx_rem_q, tx_rem_d;
  logic [CW-1:0]     rx_rem_q, rx_rem_d;
  logic              tx_neg_q, tx_neg_d;
  logic              rx_neg_q, rx_neg_d;
  logic              int_q, int_d;
  logic [SS_NB-1:0]  ss_q, ss_d;
  logic [CW-1:0]     len;
  logic              tx_edge;
  logic              rx_edge;

  assign len     = (char_len == '0) ? LEN_FULL : {1'b0, char_len};
  // Edge selects are the copies latched at go, so mid-transfer changes are ignored.
  assign tx_edge = tx_neg_q ? cpol_1 : cpol_0;
  assign rx_edge = rx_neg_q ? cpol_1 : cpol_0;

  assign last_clk = (state_q == S_RUN) && (rx_rem_q == REM_ONE);
  assign busy     = (state_q != S_IDLE);
  assign int_o    = int_q;
  assign ss_pad_o = ss_q;

  // State, counter, latched-config, interrupt and slave-select registers.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      state_q  <= S_IDLE;
      tx_rem_q <= '0;
      rx_rem_q <= '0;
      tx_neg_q <= 1'b0;
      rx_neg_q <= 1'b0;
      int_q    <= 1'b0;
      ss_q     <= '1;
    end else begin
      state_q  <= state_d;
      tx_rem_q <= tx_rem_d;
      rx_rem_q <= rx_rem_d;
      tx_neg_q <= tx_neg_d;
      rx_neg_q <= rx_neg_d;
      int_q    <= int_d;
      ss_q     <= ss_d;
    end
  end

  // Next-state, counter updates and strobe outputs.
  always_comb begin
    state_d   = state_q;
    tx_rem_d  = tx_rem_q;
    rx_rem_d  = rx_rem_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    tip       = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_sample = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d  = S_LOAD;
          tx_rem_d = len - REM_ONE;
          rx_rem_d = len;
          tx_neg_d = tx_negedge;
          rx_neg_d = rx_negedge;
        end
      end
      S_LOAD: begin
        tx_load = 1'b1;
        tip     = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        tip = 1'b1;
        if (tx_edge && (tx_rem_q != '0)) begin
          tx_shift = 1'b1;
          tx_rem_d = tx_rem_q - REM_ONE;
        end
        if (rx_edge) begin
          rx_sample = 1'b1;
          rx_rem_d  = rx_rem_q - REM_ONE;
          if (rx_rem_q == REM_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Interrupt: a set in DONE takes priority over a simultaneous acknowledge.
  always_comb begin
    int_d = int_q;
    if (int_ack) begin
      int_d = 1'b0;
    end
    if ((state_q == S_DONE) && ie) begin
      int_d = 1'b1;
    end
  end

  // Slave selects follow the next state so the registered output lines up with the state.
  always_comb begin
    ss_d = ~ss_sel;
    if (auto_ss && (state_d == S_IDLE)) begin
      ss_d = '1;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: one task per scenario, inline checks.
module tb_spi_xfer_ctrl;

  logic       clk;
  logic       wb_rst;
  logic       go;
  logic [6:0] char_len;
  logic       tx_negedge;
  logic       rx_negedge;
  logic       ie;
  logic       int_ack;
  logic       auto_ss;
  logic [7:0] ss_sel;
  logic       cpol_0;
  logic       cpol_1;
  logic       tip;
  logic       last_clk;
  logic       tx_load;
  logic       tx_shift;
  logic       rx_sample;
  logic       done;
  logic       int_o;
  logic [7:0] ss_pad_o;
  logic       busy;

  int total;
  int bad;

  spi_xfer_ctrl #(.CHAR_LEN_BITS(7), .SS_NB(8)) dut (
    .wb_clk_in  (clk),
    .wb_rst     (wb_rst),
    .go         (go),
    .char_len   (char_len),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .ie         (ie),
    .int_ack    (int_ack),
    .auto_ss    (auto_ss),
    .ss_sel     (ss_sel),
    .cpol_0     (cpol_0),
    .cpol_1     (cpol_1),
    .tip        (tip),
    .last_clk   (last_clk),
    .tx_load    (tx_load),
    .tx_shift   (tx_shift),
    .rx_sample  (rx_sample),
    .done       (done),
    .int_o      (int_o),
    .ss_pad_o   (ss_pad_o),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one transfer: go in cycle 0, edges from cycle 2 on. pat 0 alternates
  // cpol_0/cpol_1 every 2 cycles, pat 1 gives cpol_1 every 2 cycles. After
  // cycle 1 char_len and the edge selects are scrambled to prove they are
  // latched at go. Returns observed counts for the caller to check.
  task automatic run_xfer(input int len, input logic txn, input logic rxn, input int pat,
                          input logic ack_in_done, input logic go_in_run,
                          input logic [7:0] ss_act, input logic [7:0] ss_idle,
                          output int n_load, output int n_shift, output int n_samp,
                          output int n_coinc, output int n_done, output int last_bad,
                          output int ss_bad, output int post_bad, output int done_ok,
                          output int timeout, output logic int_after);
    int c, k, last_samp_cyc, done_cyc;
    logic exp_last;
    logic [7:0] exp_ss;
    n_load = 0; n_shift = 0; n_samp = 0; n_coinc = 0; n_done = 0;
    last_bad = 0; ss_bad = 0; post_bad = 0; done_ok = 0; timeout = 0;
    int_after = 1'b0;
    last_samp_cyc = -10; done_cyc = -1;
    @(posedge clk); #1;
    for (c = 0; c < 1200; c++) begin
      go         = (c == 0) || (go_in_run && c == 5);
      if (c == 0) begin
        char_len   = 7'(len);
        tx_negedge = txn;
        rx_negedge = rxn;
      end else begin
        char_len   = 7'd3;
        tx_negedge = ~txn;
        rx_negedge = ~rxn;
      end
      k = c - 2;
      cpol_0  = 1'b0;
      cpol_1  = 1'b0;
      if (c >= 2 && done_cyc < 0) begin
        if (pat == 0) begin
          cpol_0 = (k % 4 == 0);
          cpol_1 = (k % 4 == 2);
        end else begin
          cpol_1 = (k % 2 == 0);
        end
      end
      int_ack = ack_in_done && (last_samp_cyc == c - 1);
      @(negedge clk);
      exp_last = tip && !tx_load && (n_samp == len - 1);
      if (last_clk !== exp_last) last_bad++;
      if (tx_load)   n_load++;
      if (tx_shift)  n_shift++;
      if (rx_sample) begin
        n_samp++;
        if (n_samp == len) last_samp_cyc = c;
      end
      if (tx_shift && rx_sample) n_coinc++;
      if (done) begin
        n_done++;
        if (done_cyc < 0 && last_samp_cyc == c - 1) done_ok = 1;
        if (done_cyc < 0) done_cyc = c;
      end
      exp_ss = (c >= 1 && (done_cyc < 0 || c == done_cyc)) ? ss_act : ss_idle;
      if (ss_pad_o !== exp_ss) ss_bad++;
      if (done_cyc >= 0 && c > done_cyc && busy !== 1'b0) post_bad++;
      if (done_cyc >= 0 && c == done_cyc + 1) int_after = int_o;
      if (done_cyc >= 0 && c == done_cyc + 3) break;
      @(posedge clk); #1;
    end
    if (done_cyc < 0) timeout = 1;
    @(posedge clk); #1;
    go = 1'b0; cpol_0 = 1'b0; cpol_1 = 1'b0; int_ack = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1; go = 1'b0; char_len = 7'd8; tx_negedge = 1'b0; rx_negedge = 1'b0;
    ie = 1'b0; int_ack = 1'b0; auto_ss = 1'b0; ss_sel = 8'h05; cpol_0 = 1'b0; cpol_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (tip !== 1'b0) begin bad++; $display("FAIL reset_tip: got %b want 0", tip); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (ss_pad_o !== 8'hFF) begin bad++; $display("FAIL reset_ss: got %h want ff", ss_pad_o); end
    total++; if (int_o !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", int_o); end
    total++;
    if ({last_clk, tx_load, tx_shift, rx_sample, done} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 00000",
                      {last_clk, tx_load, tx_shift, rx_sample, done});
    end
    @(posedge clk); #1;
    wb_rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int c, ns, extra;
    ss_sel = 8'h05; auto_ss = 1'b0; ie = 1'b1;
    @(posedge clk); #1;
    go = 1'b1; char_len = 7'd8; tx_negedge = 1'b1; rx_negedge = 1'b0;
    ns = 0; c = 0;
    while (ns < 3 && c < 200) begin
      if (c >= 1) go = 1'b0;
      cpol_0 = (c >= 2) && ((c - 2) % 4 == 0);
      cpol_1 = (c >= 2) && ((c - 2) % 4 == 2);
      @(negedge clk);
      if (rx_sample) ns++;
      @(posedge clk); #1;
      c++;
    end
    total++; if (ns != 3) begin bad++; $display("FAIL rst_run_reach: got %0d samples want 3", ns); end
    wb_rst = 1'b1; cpol_0 = 1'b1; cpol_1 = 1'b1;
    @(posedge clk); #1;
    wb_rst = 1'b0;
    @(negedge clk);
    total++; if (tip !== 1'b0) begin bad++; $display("FAIL rst_run_tip: got %b want 0", tip); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_run_busy: got %b want 0", busy); end
    total++; if (ss_pad_o !== 8'hFF) begin bad++; $display("FAIL rst_run_ss: got %h want ff", ss_pad_o); end
    total++;
    if ({rx_sample, tx_shift, last_clk} !== 3'b0) begin
      bad++; $display("FAIL rst_run_pulse: got %b want 000", {rx_sample, tx_shift, last_clk});
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cpol_0 = (i % 4 == 0);
      cpol_1 = (i % 4 == 2);
      @(negedge clk);
      if (tx_load || tx_shift || rx_sample || done || tip) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL rst_run_quiet: got %0d pulse cycles want 0", extra); end
    total++; if (int_o !== 1'b0) begin bad++; $display("FAIL rst_run_int: got %b want 0", int_o); end
    @(posedge clk); #1;
    cpol_0 = 1'b0; cpol_1 = 1'b0;
  endtask

  task automatic test_basic8();
    int nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to;
    logic ia;
    ie = 1'b0; auto_ss = 1'b0; ss_sel = 8'h05;
    run_xfer(8, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'hFA, 8'hFA,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (to != 0) begin bad++; $display("FAIL b8_timeout: got no done want done"); end
    total++; if (nl != 1) begin bad++; $display("FAIL b8_load: got %0d want 1", nl); end
    total++; if (nsh != 7) begin bad++; $display("FAIL b8_shift: got %0d want 7", nsh); end
    total++; if (nsa != 8) begin bad++; $display("FAIL b8_sample: got %0d want 8", nsa); end
    total++; if (lb != 0) begin bad++; $display("FAIL b8_last_clk: got %0d wrong cycles want 0", lb); end
    total++; if (dok != 1 || nd != 1) begin bad++; $display("FAIL b8_done: got ok=%0d n=%0d want ok=1 n=1", dok, nd); end
    total++; if (pb != 0) begin bad++; $display("FAIL b8_idle_after: got %0d busy cycles want 0", pb); end
  endtask

  task automatic test_char_len_max();
    int nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to;
    logic ia;
    run_xfer(128, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'hFA, 8'hFA,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (to != 0) begin bad++; $display("FAIL l128_timeout: got no done want done"); end
    total++; if (nsa != 128) begin bad++; $display("FAIL l128_sample: got %0d want 128", nsa); end
    total++; if (nsh != 127) begin bad++; $display("FAIL l128_shift: got %0d want 127", nsh); end
    total++; if (lb != 0) begin bad++; $display("FAIL l128_last_clk: got %0d wrong cycles want 0", lb); end
    total++; if (dok != 1) begin bad++; $display("FAIL l128_done: got %0d want 1", dok); end
  endtask

  task automatic test_coincident_edges();
    int nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to;
    logic ia;
    run_xfer(8, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'hFA, 8'hFA,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (nl != 1) begin bad++; $display("FAIL co_load: got %0d want 1", nl); end
    total++; if (nsh != 7) begin bad++; $display("FAIL co_shift: got %0d want 7", nsh); end
    total++; if (nsa != 8) begin bad++; $display("FAIL co_sample: got %0d want 8", nsa); end
    total++; if (nco != 7) begin bad++; $display("FAIL co_coincide: got %0d want 7", nco); end
    total++; if (dok != 1) begin bad++; $display("FAIL co_done: got %0d want 1", dok); end
  endtask

  task automatic test_slave_select();
    int nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to;
    logic ia;
    auto_ss = 1'b1; ss_sel = 8'h05;
    run_xfer(3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'hFA, 8'hFF,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (sb != 0 || to != 0) begin bad++; $display("FAIL ss_auto: got %0d bad cycles want 0", sb); end
    auto_ss = 1'b0;
    run_xfer(3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'hFA, 8'hFA,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (sb != 0 || to != 0) begin bad++; $display("FAIL ss_manual: got %0d bad cycles want 0", sb); end
  endtask

  task automatic test_interrupt();
    int nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to;
    logic ia;
    ie = 1'b1;
    run_xfer(4, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'hFA, 8'hFA,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (ia !== 1'b1) begin bad++; $display("FAIL int_set_wins: got %b want 1", ia); end
    total++; if (nl != 1 || nd != 1) begin bad++; $display("FAIL go_ignored: got loads=%0d dones=%0d want 1/1", nl, nd); end
    total++; if (pb != 0) begin bad++; $display("FAIL go_no_queue: got %0d busy cycles want 0", pb); end
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    @(negedge clk);
    total++; if (int_o !== 1'b0) begin bad++; $display("FAIL int_ack_clear: got %b want 0", int_o); end
    ie = 1'b0;
    run_xfer(2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'hFA, 8'hFA,
             nl, nsh, nsa, nco, nd, lb, sb, pb, dok, to, ia);
    total++; if (ia !== 1'b0 || to != 0) begin bad++; $display("FAIL int_disabled: got %b want 0", ia); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_reset_mid_run();
    test_basic8();
    test_char_len_max();
    test_coincident_edges();
    test_slave_select();
    test_interrupt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
